// File: rtl/xpb_pkg.sv
// xpb_pkg: shared sizes and state encoding for the XPB lookup sequencer
package xpb_pkg;
  localparam int DIGIT_W = 5;
  localparam int NUM_DIGITS = 8;
  localparam int DATA_W = 1024;
  localparam int BANK_W = $clog2(NUM_DIGITS);
  localparam int ACC_W = DATA_W + $clog2(NUM_DIGITS + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/xpb_lookup_seq_if.sv
// xpb_lookup_seq_if: digit input stream, LUT port and sum output stream
interface xpb_lookup_seq_if;
  import xpb_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [NUM_DIGITS*DIGIT_W-1:0] in_digits;
  logic lut_en;
  logic [BANK_W-1:0] lut_bank;
  logic [DIGIT_W-1:0] lut_digit;
  logic [DATA_W-1:0] lut_data;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out_sum;
  modport slave (
    input in_valid, in_digits, lut_data, out_ready,
    output in_ready, lut_en, lut_bank, lut_digit, out_valid, out_sum
  );
  modport master (
    output in_valid, in_digits, lut_data, out_ready,
    input in_ready, lut_en, lut_bank, lut_digit, out_valid, out_sum
  );
endinterface

// File: rtl/xpb_accum.sv
// xpb_accum: un-reduced sum of LUT results, gated by a one-cycle delayed lookup strobe
module xpb_accum import xpb_pkg::*; (
  input logic clk,
  input logic rst_n,
  input logic clr,
  input logic en,
  input logic [DATA_W-1:0] data,
  output logic [ACC_W-1:0] acc
);
  logic dv;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dv <= 1'b0;
      acc <= '0;
    end else begin
      dv <= en;
      acc <= clr ? '0 : dv ? acc + ACC_W'(data) : acc;
    end
endmodule

// File: rtl/xpb_lookup_seq.sv
// xpb_lookup_seq: steps digits through a shared XPB LUT port and accumulates the results
module xpb_lookup_seq import xpb_pkg::*; (
  input logic clk,
  input logic rst_n,
  xpb_lookup_seq_if.slave bus
);
  state_t state;
  logic [BANK_W-1:0] k;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits;
  logic in_ready;
  logic lut_en;
  logic out_valid;
  logic accept;
  logic [ACC_W-1:0] acc;
  assign accept = in_ready && bus.in_valid;
  assign bus.in_ready = in_ready;
  assign bus.lut_en = lut_en;
  assign bus.lut_bank = k;
  assign bus.lut_digit = digits[32'(k)*DIGIT_W +: DIGIT_W];
  assign bus.out_valid = out_valid;
  assign bus.out_sum = acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      digits <= '0;
      in_ready <= 1'b1;
      lut_en <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= ISSUE;
          digits <= bus.in_digits;
          k <= '0;
          in_ready <= 1'b0;
          lut_en <= 1'b1;
        end
        ISSUE: begin
          k <= k + 1'b1;
          if (k == BANK_W'(NUM_DIGITS - 1)) begin
            state <= DRAIN;
            lut_en <= 1'b0;
          end
        end
        DRAIN: begin
          state <= DONE;
          out_valid <= 1'b1;
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  xpb_accum u_accum (
    .clk(clk),
    .rst_n(rst_n),
    .clr(accept),
    .en(lut_en),
    .data(bus.lut_data),
    .acc(acc)
  );
endmodule

// File: tb/tb_xpb_lookup_seq.sv
// tb_xpb_lookup_seq: randomized checks of the XPB lookup sequencer against a golden sum
module tb_xpb_lookup_seq;
  import xpb_pkg::*;
  typedef logic [NUM_DIGITS*DIGIT_W-1:0] vec_t;
  typedef logic [ACC_W-1:0] sum_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  int tests = 0;
  int fails = 0;
  xpb_lookup_seq_if bus();
  xpb_lookup_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [DATA_W-1:0] xpb(input logic m, input int bank, input int digit);
    logic [DATA_W-1:0] r;
    logic [31:0] w;
    if (m) return '1;
    if (digit == 0) return '0;
    for (int i = 0; i < DATA_W / 32; i++) begin
      w = 32'(bank * 1000003 + digit * 7919 + i * 104729 + 1) * 32'h9E3779B9;
      w = w ^ (w >> 13);
      r[i*32 +: 32] = w;
    end
    return r;
  endfunction
  function automatic sum_t golden(input logic m, input vec_t d);
    sum_t s = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      s += sum_t'(xpb(m, k, int'(d[k*DIGIT_W +: DIGIT_W])));
    return s;
  endfunction
  function automatic vec_t rand_vec();
    return vec_t'({$urandom(), $urandom()});
  endfunction
  always @(posedge clk)
    bus.lut_data <= bus.lut_en ? xpb(mode, int'(bus.lut_bank), int'(bus.lut_digit)) : ~xpb(1'b0, 7, 31);
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input vec_t d);
    bus.in_digits = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.in_ready; i++) step();
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(output int n);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
  endtask
  task automatic test_reset();
    step();
    step();
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.lut_en, bus.lut_bank, bus.lut_digit} !== {1'b1, 1'b0, 1'b0, BANK_W'(0), DIGIT_W'(0)}) begin
      fails++;
      $display("FAIL reset_ctrl: got rdy=%b ov=%b en=%b bank=%0d dig=%0d, want 1 0 0 0 0", bus.in_ready, bus.out_valid, bus.lut_en, bus.lut_bank, bus.lut_digit);
    end
    tests++;
    if (bus.out_sum !== '0) begin
      fails++;
      $display("FAIL reset_sum: got nonzero low=%h, want 0", bus.out_sum[63:0]);
    end
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_zero();
    int n;
    send('0);
    wait_out(n);
    tests++;
    if (n != NUM_DIGITS + 2) begin
      fails++;
      $display("FAIL zero_latency: got %0d, want %0d", n, NUM_DIGITS + 2);
    end
    tests++;
    if (bus.out_sum !== golden(1'b0, '0)) begin
      fails++;
      $display("FAIL zero_sum: got low=%h, want 0", bus.out_sum[63:0]);
    end
    step();
  endtask
  task automatic test_bank_seq();
    vec_t d = vec_t'(1);
    int n;
    send(d);
    for (int c = 1; c <= NUM_DIGITS; c++) begin
      tests++;
      if ({bus.lut_en, bus.lut_bank, bus.lut_digit} !== {1'b1, BANK_W'(c - 1), d[(c-1)*DIGIT_W +: DIGIT_W]}) begin
        fails++;
        $display("FAIL bank_seq: cycle %0d got en=%b bank=%0d dig=%0d, want 1 %0d %0d", c, bus.lut_en, bus.lut_bank, bus.lut_digit, c - 1, d[(c-1)*DIGIT_W +: DIGIT_W]);
      end
      step();
    end
    tests++;
    if (bus.lut_en !== 1'b0) begin
      fails++;
      $display("FAIL drain_en: got %b, want 0", bus.lut_en);
    end
    wait_out(n);
    tests++;
    if (bus.out_sum !== sum_t'(xpb(1'b0, 0, 1))) begin
      fails++;
      $display("FAIL single_digit: got low=%h, want low=%h", bus.out_sum[63:0], xpb(1'b0, 0, 1) & 64'hFFFF_FFFF_FFFF_FFFF);
    end
    step();
  endtask
  task automatic test_all_ones();
    sum_t exp = (sum_t'(1) << (DATA_W + 3)) - sum_t'(8);
    int n;
    mode = 1'b1;
    send(rand_vec());
    wait_out(n);
    tests++;
    if (bus.out_sum !== exp) begin
      fails++;
      $display("FAIL all_ones_sum: got top=%h low=%h, want top=7 low=%h", bus.out_sum[ACC_W-1 -: 4], bus.out_sum[63:0], exp[63:0]);
    end
    tests++;
    if (bus.out_sum[ACC_W-1 -: 4] !== 4'h7) begin
      fails++;
      $display("FAIL all_ones_carry: got %h, want 7", bus.out_sum[ACC_W-1 -: 4]);
    end
    step();
    mode = 1'b0;
  endtask
  task automatic test_backpressure();
    vec_t d1 = rand_vec();
    vec_t d2 = rand_vec();
    int n;
    bus.out_ready = 1'b0;
    send(d1);
    wait_out(n);
    bus.in_digits = d2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.out_sum !== golden(1'b0, d1)) begin
        fails++;
        $display("FAIL hold: cycle %0d got ov=%b rdy=%b low=%h, want 1 0 low=%h", i, bus.out_valid, bus.in_ready, bus.out_sum[63:0], golden(1'b0, d1) & 64'hFFFF_FFFF_FFFF_FFFF);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL release: got ov=%b rdy=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.lut_en, bus.in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL reaccept: got en=%b rdy=%b, want 1 0", bus.lut_en, bus.in_ready);
    end
    wait_out(n);
    tests++;
    if (n != NUM_DIGITS + 2 || bus.out_sum !== golden(1'b0, d2)) begin
      fails++;
      $display("FAIL second_sum: got lat=%0d low=%h, want %0d low=%h", n, bus.out_sum[63:0], NUM_DIGITS + 2, golden(1'b0, d2) & 64'hFFFF_FFFF_FFFF_FFFF);
    end
    step();
  endtask
  task automatic test_reset_mid();
    vec_t d2 = rand_vec();
    int n;
    send(rand_vec());
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.out_valid, bus.lut_en, bus.in_ready} !== 3'b001 || bus.out_sum !== '0) begin
      fails++;
      $display("FAIL mid_reset: got ov=%b en=%b rdy=%b low=%h, want 0 0 1 0", bus.out_valid, bus.lut_en, bus.in_ready, bus.out_sum[63:0]);
    end
    step();
    rst_n = 1'b1;
    step();
    send(d2);
    wait_out(n);
    tests++;
    if (bus.out_sum !== golden(1'b0, d2)) begin
      fails++;
      $display("FAIL after_abort: got low=%h, want low=%h", bus.out_sum[63:0], golden(1'b0, d2) & 64'hFFFF_FFFF_FFFF_FFFF);
    end
    step();
  endtask
  task automatic test_back_to_back();
    sum_t q[$];
    sum_t s;
    sum_t e;
    vec_t cur = rand_vec();
    int acc_n = 0;
    int chk_n = 0;
    logic ir, iv, ov, ordy;
    bus.in_digits = cur;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3000 && chk_n < 20; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      ir = bus.in_ready;
      iv = bus.in_valid;
      ov = bus.out_valid;
      ordy = bus.out_ready;
      s = bus.out_sum;
      step();
      if (ir && iv) begin
        q.push_back(golden(1'b0, cur));
        acc_n++;
        cur = rand_vec();
        bus.in_digits = cur;
        if (acc_n == 20) bus.in_valid = 1'b0;
      end
      if (ov && ordy) begin
        e = q.size() > 0 ? q.pop_front() : '0;
        tests++;
        if (s !== e) begin
          fails++;
          $display("FAIL b2b_sum: #%0d got low=%h, want low=%h", chk_n, s[63:0], e[63:0]);
        end
        chk_n++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tests++;
    if (chk_n != 20) begin
      fails++;
      $display("FAIL b2b_count: got %0d results, want 20", chk_n);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_digits = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_zero();
    test_bank_seq();
    test_all_ones();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
